if_prefetch_stage: RTL and testbench
====================================

Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage that replaces the single-PC, combinational-memory fetch with a decoupled prefetcher. It issues requests to a variable-latency instruction memory through a req/ack handshake and buffers returned instructions, each paired with its PC+step value, in a DEPTH-entry FIFO. It feeds the IF/ID register and supports branch redirect with flush of buffered and in-flight fetches, plus the pipeline freeze and the global SRAM freeze.

Parameters:
ADDR_W, 32, PC and memory address width
INSTR_W, 32, instruction width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
PC_STEP, 4, byte increment between sequential fetches
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
freeze  in  1  hazard stall from ID; blocks pop
sram_freeze  in  1  global data-memory stall; blocks pop, issue and redirect
branch_taken  in  1  redirect request from EXE
branch_addr  in  ADDR_W  redirect target
mem_req  out  1  fetch request, held until acknowledged
mem_addr  out  ADDR_W  fetch address, stable while mem_req=1
mem_ack  in  1  memory returns mem_rdata this cycle (sampled at the edge)
mem_rdata  in  INSTR_W  instruction for the outstanding request
valid  out  1  FIFO head holds a usable instruction
instruction  out  INSTR_W  head instruction; 0 (NOP) when valid=0
pc  out  ADDR_W  head fetch address + PC_STEP; 0 when valid=0

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: fetch_pc=RESET_PC, FIFO empty, state IDLE, drop=0, mem_req=0, valid=0, instruction=0, pc=0.
- FSM states:
  - IDLE: mem_req=0. Move to WAIT when sram_freeze=0 and count + pop < DEPTH. In that cycle mem_req=1 and mem_addr=fetch_pc (combinational issue).
  - WAIT: mem_req=1 and mem_addr held constant until mem_ack.
  - On ack with drop=0: push {mem_rdata, mem_addr+PC_STEP} and set fetch_pc+=PC_STEP.
  - After ack: if the issue condition still holds, the next request goes out the following cycle. Stay in WAIT (back-to-back) with the new address; otherwise go to IDLE.
- At most one outstanding request.
- Throughput with a zero-wait memory (ack in the request cycle) is one instruction per cycle.
- Latency: an instruction acked at edge N is at the FIFO head, with valid=1, in cycle N+1.
- Pop: occurs at the edge when valid=1, freeze=0 and sram_freeze=0.
- Simultaneous push and pop are allowed. FIFO pointers wrap modulo DEPTH.
- Overflow cannot occur because issue is gated on free space. Count must never exceed DEPTH, and an assertion checks this.
- Redirect: branch_taken=1 with sram_freeze=0, at the edge:
  - FIFO is flushed (count=0) and fetch_pc=branch_addr.
  - If in WAIT without an ack that cycle: set drop=1. The request stays asserted, unchanged, until ack; the ack clears drop and discards the data. The next issue is from branch_addr.
  - If ack coincides with the branch: the data is discarded and drop stays 0.
  - valid=0 in the cycle after the branch. Nothing is popped in the branch cycle.
- sram_freeze=1:
  - No pop, no new issue, branch_taken ignored (EXE holds it).
  - An in-flight ack is still accepted and pushed, so the memory handshake never stalls.
- Address arithmetic wraps modulo 2^ADDR_W.
- Reset mid-operation: immediate return to reset values. Any in-flight memory transaction is abandoned; the memory controller is reset by the same rst.

Test Plan:
1. Reset release, zero-wait memory (ack=req, rdata=addr>>2), freeze=0 -> mem_addr 0,4,8,... on consecutive cycles; valid=1 from cycle 2; pc=4,8,12 each cycle.
2. freeze=1 held 10 cycles, DEPTH=4, zero-wait memory -> exactly 4 pushes then mem_req=0; head unchanged (pc=4). On release, 4 instructions drain in order, then fetching resumes at address 16.
3. Memory with 3-cycle ack latency -> mem_addr stable for 3 cycles per request; valid pulses once every 3 cycles; no duplicate or lost PCs.
4. branch_taken with branch_addr=0x100 while a request to 0x20 is in flight (ack 2 cycles later) -> 0x20 data discarded; FIFO empty; next mem_addr=0x100; first valid instruction has pc=0x104.
5. branch_taken coincident with mem_ack, and a separate case of branch_taken during sram_freeze=1 -> first: acked data dropped and next fetch is at the target. Second: branch ignored, sequential fetch unchanged, no pop occurs, and the in-flight ack is still pushed.
6. Async rst asserted mid-WAIT between clock edges -> mem_req, valid, instruction and pc go to 0 immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory fetch bus between the prefetch stage and the memory.
// Ports: mem_req/mem_addr (master out), mem_ack/mem_rdata (master in).
interface if_prefetch_stage_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) ();
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// Decoupled instruction prefetcher: req/ack fetch into a DEPTH-entry FIFO.
// Ports: clk, rst, freeze, sram_freeze, branch_taken/addr, mem bus, valid/instruction/pc.
module if_prefetch_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                sram_freeze,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_addr,
    if_prefetch_stage_if.master mem,
    output logic                valid,
    output logic [INSTR_W-1:0]  instruction,
    output logic [ADDR_W-1:0]   pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]         state, state_nxt;
    logic               drop;
    logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt, req_addr;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [PTR_W:0]     count, count_nxt;
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic               redirect, pop, ack, push;
    logic               can_issue, can_next;

    assign redirect = branch_taken & ~sram_freeze;
    assign valid    = (count != '0);
    // the branch cycle never pops; the flush discards the head anyway
    assign pop = valid & ~freeze & ~sram_freeze & ~branch_taken;

    // rst gates the combinational issue so mem_req drops immediately
    assign can_issue = ~rst & ~sram_freeze
                     & ((count + (PTR_W+1)'(pop)) < FULL);

    assign mem.mem_req  = (state == WAIT) | can_issue;
    assign mem.mem_addr = (state == WAIT) ? req_addr : fetch_pc;

    assign ack  = mem.mem_req & mem.mem_ack;
    // data returned for a pre-redirect request is discarded
    assign push = ack & ~drop & ~redirect;

    always_comb begin
        fetch_pc_nxt = fetch_pc;
        count_nxt    = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        if (redirect) begin
            fetch_pc_nxt = branch_addr;
            count_nxt    = '0;
        end else if (push) begin
            fetch_pc_nxt = fetch_pc + STEP;
        end
    end

    // room for the next push decides back-to-back issue after an ack
    assign can_next = ~sram_freeze & (count_nxt < FULL);

    always_comb begin
        state_nxt = IDLE;
        if (mem.mem_req & ~ack)
            state_nxt = WAIT;
        else if (ack & can_next)
            state_nxt = WAIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            drop     <= 1'b0;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;
            // hold an unacked request; otherwise preload the next address
            if (mem.mem_req & ~ack)
                req_addr <= mem.mem_addr;
            else
                req_addr <= fetch_pc_nxt;
            if (ack)
                drop <= 1'b0;
            else if (redirect & mem.mem_req)
                drop <= 1'b1;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= mem.mem_rdata;
            fifo_pc[wr_ptr]    <= fetch_pc + STEP;
        end
    end

    assign instruction = valid ? fifo_instr[rd_ptr] : '0;
    assign pc          = valid ? fifo_pc[rd_ptr]    : '0;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) count <= FULL
    );
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with a configurable-latency memory.
// Memory returns addr>>2; lat<=1 acks in the request cycle.
module tb_if_prefetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        sram_freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wcnt;
    logic        ev;
    logic [31:0] ep, ei, ea;

    if_prefetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) m ();

    if_prefetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .sram_freeze  (sram_freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem          (m.master),
        .valid        (valid),
        .instruction  (instruction),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wcnt <= 0;
        else if (m.mem_req && !m.mem_ack)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    always_comb begin
        m.mem_ack   = m.mem_req && (lat <= 1 || wcnt == lat - 1);
        m.mem_rdata = m.mem_addr >> 2;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        freeze = 1'b0;
        sram_freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = '0;
        lat = l;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        lat = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m.mem_req, valid, pc, instruction} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outs got req=%b v=%b pc=%h i=%h exp 0",
                     m.mem_req, valid, pc, instruction);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m.mem_req, m.mem_addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_issue got req=%b a=%h v=%b exp 1 0 0",
                     m.mem_req, m.mem_addr, valid);
        end
    endtask

    task automatic test_sequential();
        do_reset(0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ea = 32'(4 * k);
            ev = (k >= 1);
            ep = ev ? 32'(4 * k) : 32'h0;
            ei = ev ? 32'(k - 1) : 32'h0;
            checks++;
            if ({m.mem_req, m.mem_addr} !== {1'b1, ea}) begin
                errors++;
                $display("FAIL seq_addr k=%0d got %b %h exp 1 %h",
                         k, m.mem_req, m.mem_addr, ea);
            end
            checks++;
            if ({valid, pc, instruction} !== {ev, ep, ei}) begin
                errors++;
                $display("FAIL seq_head k=%0d got %b %h %h exp %b %h %h",
                         k, valid, pc, instruction, ev, ep, ei);
            end
            nxt();
        end
    endtask

    task automatic test_freeze();
        do_reset(0);
        freeze = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (m.mem_req !== (k < 4)) begin
                errors++;
                $display("FAIL frz_req k=%0d got %b exp %b",
                         k, m.mem_req, (k < 4));
            end
            if (k >= 1) begin
                checks++;
                if ({valid, pc, instruction} !== {1'b1, 32'h4, 32'h0}) begin
                    errors++;
                    $display("FAIL frz_head k=%0d got %b %h %h exp 1 4 0",
                             k, valid, pc, instruction);
                end
            end
            nxt();
        end
        freeze = 1'b0;
        for (int k = 10; k < 16; k++) begin
            @(negedge clk);
            ep = 32'(4 * (k - 9));
            ei = 32'(k - 10);
            checks++;
            if ({valid, pc, instruction} !== {1'b1, ep, ei}) begin
                errors++;
                $display("FAIL drain_head k=%0d got %b %h %h exp 1 %h %h",
                         k, valid, pc, instruction, ep, ei);
            end
            checks++;
            if (m.mem_req !== (k >= 12)) begin
                errors++;
                $display("FAIL drain_req k=%0d got %b exp %b",
                         k, m.mem_req, (k >= 12));
            end
            if (k == 12 || k == 13) begin
                ea = (k == 12) ? 32'h10 : 32'h14;
                checks++;
                if (m.mem_addr !== ea) begin
                    errors++;
                    $display("FAIL drain_addr k=%0d got %h exp %h",
                             k, m.mem_addr, ea);
                end
            end
            nxt();
        end
    endtask

    task automatic test_latency();
        do_reset(3);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ea = 32'(4 * (k / 3));
            ev = (k % 3 == 0) && (k >= 3);
            ep = ev ? 32'(4 * (k / 3)) : 32'h0;
            ei = ev ? 32'(k / 3 - 1) : 32'h0;
            checks++;
            if ({m.mem_req, m.mem_addr} !== {1'b1, ea}) begin
                errors++;
                $display("FAIL lat_addr k=%0d got %b %h exp 1 %h",
                         k, m.mem_req, m.mem_addr, ea);
            end
            checks++;
            if ({valid, pc, instruction} !== {ev, ep, ei}) begin
                errors++;
                $display("FAIL lat_head k=%0d got %b %h %h exp %b %h %h",
                         k, valid, pc, instruction, ev, ep, ei);
            end
            nxt();
        end
    endtask

    task automatic test_branch_inflight();
        logic [31:0] t_addr [6] = '{32'h20, 32'h20, 32'h100,
                                    32'h100, 32'h100, 32'h104};
        do_reset(3);
        repeat (24) nxt();
        branch_taken = 1'b1;
        branch_addr = 32'h100;
        @(negedge clk);
        checks++;
        if ({valid, pc, m.mem_addr} !== {1'b1, 32'h20, 32'h20}) begin
            errors++;
            $display("FAIL brf_pre got %b %h %h exp 1 20 20",
                     valid, pc, m.mem_addr);
        end
        nxt();
        branch_taken = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ev = (k == 5);
            ep = ev ? 32'h104 : 32'h0;
            ei = ev ? 32'h40 : 32'h0;
            checks++;
            if ({m.mem_req, m.mem_addr} !== {1'b1, t_addr[k]}) begin
                errors++;
                $display("FAIL brf_addr k=%0d got %b %h exp 1 %h",
                         k, m.mem_req, m.mem_addr, t_addr[k]);
            end
            checks++;
            if ({valid, pc, instruction} !== {ev, ep, ei}) begin
                errors++;
                $display("FAIL brf_head k=%0d got %b %h %h exp %b %h %h",
                         k, valid, pc, instruction, ev, ep, ei);
            end
            nxt();
        end
    endtask

    task automatic test_branch_ack();
        do_reset(0);
        repeat (3) nxt();
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        @(negedge clk);
        checks++;
        if ({m.mem_ack, m.mem_addr} !== {1'b1, 32'hc}) begin
            errors++;
            $display("FAIL bra_pre got %b %h exp 1 c", m.mem_ack, m.mem_addr);
        end
        nxt();
        branch_taken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ea = 32'h200 + 32'(4 * k);
            ev = (k >= 1);
            ep = ev ? 32'h200 + 32'(4 * k) : 32'h0;
            ei = ev ? 32'h80 + 32'(k - 1) : 32'h0;
            checks++;
            if ({m.mem_req, m.mem_addr} !== {1'b1, ea}) begin
                errors++;
                $display("FAIL bra_addr k=%0d got %b %h exp 1 %h",
                         k, m.mem_req, m.mem_addr, ea);
            end
            checks++;
            if ({valid, pc, instruction} !== {ev, ep, ei}) begin
                errors++;
                $display("FAIL bra_head k=%0d got %b %h %h exp %b %h %h",
                         k, valid, pc, instruction, ev, ep, ei);
            end
            nxt();
        end
    endtask

    task automatic test_branch_sram_freeze();
        logic        t_req  [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        logic [31:0] t_addr [8] = '{4, 4, 4, 0, 8, 8, 8, 12};
        logic        t_v    [8] = '{1, 1, 1, 1, 1, 1, 0, 1};
        logic [31:0] t_pc   [8] = '{4, 4, 4, 4, 4, 8, 0, 12};
        logic [31:0] t_i    [8] = '{0, 0, 0, 0, 0, 1, 0, 2};
        do_reset(3);
        repeat (3) nxt();
        for (int k = 0; k < 8; k++) begin
            sram_freeze = (k < 4);
            branch_taken = (k < 4);
            branch_addr = 32'h300;
            @(negedge clk);
            checks++;
            if (m.mem_req !== t_req[k] ||
                (t_req[k] && m.mem_addr !== t_addr[k])) begin
                errors++;
                $display("FAIL sfz_req k=%0d got %b %h exp %b %h",
                         k, m.mem_req, m.mem_addr, t_req[k], t_addr[k]);
            end
            checks++;
            if ({valid, pc, instruction} !== {t_v[k], t_pc[k], t_i[k]}) begin
                errors++;
                $display("FAIL sfz_head k=%0d got %b %h %h exp %b %h %h",
                         k, valid, pc, instruction, t_v[k], t_pc[k], t_i[k]);
            end
            nxt();
        end
        sram_freeze = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset(3);
        repeat (3) nxt();
        @(negedge clk);
        checks++;
        if ({m.mem_req, valid, pc} !== {1'b1, 1'b1, 32'h4}) begin
            errors++;
            $display("FAIL arst_pre got %b %b %h exp 1 1 4",
                     m.mem_req, valid, pc);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m.mem_req, valid, pc, instruction} !== 66'd0) begin
            errors++;
            $display("FAIL arst_async got req=%b v=%b pc=%h i=%h exp 0",
                     m.mem_req, valid, pc, instruction);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ea = (k == 3) ? 32'h4 : 32'h0;
            ev = (k == 3);
            ep = ev ? 32'h4 : 32'h0;
            checks++;
            if ({m.mem_req, m.mem_addr, valid, pc, instruction}
                !== {1'b1, ea, ev, ep, 32'h0}) begin
                errors++;
                $display("FAIL arst_restart k=%0d got %b %h %b %h %h exp 1 %h %b %h 0",
                         k, m.mem_req, m.mem_addr, valid, pc, instruction,
                         ea, ev, ep);
            end
            nxt();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_latency();
        test_branch_inflight();
        test_branch_ack();
        test_branch_sram_freeze();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
